// File: rtl/led_frame_ctrl_if.sv
// Byte-stream and frame-engine signals of the LED frame sequencer.
// spi_rdy_in is a one-cycle strobe qualifying spi_data_in; ram_wr_en_out is a
// one-cycle strobe qualifying address/data; frame_start_out is a one-cycle
// request that is only raised while frame_busy_in is low.
interface led_frame_ctrl_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  spi_rdy_in;
  logic [7:0]            spi_data_in;
  logic                  frame_busy_in;
  logic                  ram_wr_en_out;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_out;
  logic [7:0]            ram_wr_data_out;
  logic [ADDR_WIDTH:0]   frame_len_out;
  logic                  frame_start_out;
  logic                  err_out;
  logic [1:0]            dbg_state_out;

  modport master (
    input  spi_rdy_in, spi_data_in, frame_busy_in,
    output ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out,
    output frame_len_out, frame_start_out, err_out, dbg_state_out
  );

  modport slave (
    output spi_rdy_in, spi_data_in, frame_busy_in,
    input  ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out,
    input  frame_len_out, frame_start_out, err_out, dbg_state_out
  );
endinterface

// File: rtl/led_frame_ctrl.sv
// Command sequencer: decodes set-length / stream-pixels / show-frame bytes,
// writes the frame RAM and hands finished frames to the output engine.
module led_frame_ctrl #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             spi_cs_n_in,
  led_frame_ctrl_if.master bus
);

  localparam int          LEN_W   = ADDR_WIDTH + 1;
  localparam logic [16:0] LEN_MAX = 17'(1) << ADDR_WIDTH;

  // Encoding is visible on dbg_state_out: 0 IDLE, 1 LEN_H, 2 LEN_L, 3 DATA.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEN_H = 2'd1,
    LEN_L = 2'd2,
    DATA  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  cs_meta_q;
  logic                  cs_sync_q;
  logic                  cs_prev_q;
  logic [7:0]            len_hi_q;
  logic [LEN_W-1:0]      wr_ptr_q;
  logic                  show_pend_q;
  logic                  ram_wr_en_q;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_q;
  logic [7:0]            ram_wr_data_q;
  logic [LEN_W-1:0]      frame_len_q;
  logic                  frame_start_q;
  logic                  err_q;

  logic        cs_end;
  logic [15:0] len_word;
  logic        len_ok;

  assign cs_end   = cs_sync_q & ~cs_prev_q;
  assign len_word = {len_hi_q, bus.spi_data_in};
  assign len_ok   = (len_word != 16'd0) && ({1'b0, len_word} <= LEN_MAX);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      cs_meta_q     <= 1'b1;
      cs_sync_q     <= 1'b1;
      cs_prev_q     <= 1'b1;
      len_hi_q      <= 8'd0;
      wr_ptr_q      <= '0;
      show_pend_q   <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= 8'd0;
      frame_len_q   <= '0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cs_meta_q     <= spi_cs_n_in;
      cs_sync_q     <= cs_meta_q;
      cs_prev_q     <= cs_sync_q;
      ram_wr_en_q   <= 1'b0;
      frame_start_q <= 1'b0;

      // An empty frame is never started; the request is simply dropped.
      if (show_pend_q && !bus.frame_busy_in) begin
        show_pend_q   <= 1'b0;
        frame_start_q <= (frame_len_q != '0);
      end

      if (bus.spi_rdy_in) begin
        case (state_q)
          IDLE: begin
            case (bus.spi_data_in)
              8'h2A: state_q <= LEN_H;
              8'h2B: begin
                wr_ptr_q <= '0;
                state_q  <= DATA;
              end
              8'h2C:   show_pend_q <= 1'b1;
              default: state_q     <= IDLE;
            endcase
          end
          LEN_H: begin
            len_hi_q <= bus.spi_data_in;
            state_q  <= LEN_L;
          end
          LEN_L: begin
            if (len_ok) begin
              frame_len_q <= len_word[LEN_W-1:0];
              err_q       <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          DATA: begin
            if (wr_ptr_q < frame_len_q) begin
              ram_wr_en_q   <= 1'b1;
              ram_wr_addr_q <= wr_ptr_q[ADDR_WIDTH-1:0];
              ram_wr_data_q <= bus.spi_data_in;
              wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      // End of transaction wins over any transition taken by the same byte.
      if (cs_end) begin
        state_q <= IDLE;
      end
    end
  end

  assign bus.ram_wr_en_out   = ram_wr_en_q;
  assign bus.ram_wr_addr_out = ram_wr_addr_q;
  assign bus.ram_wr_data_out = ram_wr_data_q;
  assign bus.frame_len_out   = frame_len_q;
  assign bus.frame_start_out = frame_start_q;
  assign bus.err_out         = err_q;
  assign bus.dbg_state_out   = state_q;

endmodule

// File: doc/led_frame_ctrl.md
# led_frame_ctrl

Command sequencer between the SPI byte receiver and the NeoPixel output engine. Consumes the receiver's single-cycle byte-ready pulses and bytes in the `clk_in` domain and decodes a three-command protocol: set frame length, stream pixel bytes, show frame. It writes pixel bytes into the frame RAM and hands complete frames to the output engine over a start/busy handshake.

## Interface
- `ADDR_WIDTH`, 9: frame RAM address width; RAM depth is 2**ADDR_WIDTH bytes.
- `clk_in`  input  1  system clock.
- `rst_n_in`  input  1  reset, asynchronous assert, active-low; all flops reset.
- `spi_cs_n_in`  input  1  raw SPI chip select from pin, asynchronous to `clk_in`.
- `spi_rdy_in`  input  1  byte-valid, single `clk_in`-cycle pulse from the receiver.
- `spi_data_in`  input  8  received byte, stable while `spi_rdy_in` is high.
- `frame_busy_in`  input  1  output engine is shifting a frame.
- `ram_wr_en_out`  output  1  frame RAM write strobe.
- `ram_wr_addr_out`  output  ADDR_WIDTH  frame RAM write address.
- `ram_wr_data_out`  output  8  frame RAM write data.
- `frame_len_out`  output  ADDR_WIDTH+1  committed frame length in bytes.
- `frame_start_out`  output  1  single-cycle start pulse to the output engine.
- `err_out`  output  1  sticky bad-length flag.

## Operation
- `spi_cs_n_in` passes through a 2-flop synchronizer, reset value 1. A rising edge of the synchronized value (`cs_end`) ends the transaction.
- FSM states:
  - **IDLE**: byte 0x2A goes to LEN_H; 0x2B clears the write pointer and goes to DATA; 0x2C sets `show_pend`; any other byte is ignored and the FSM stays in IDLE.
  - **LEN_H**: latches the byte as `len_tmp[15:8]`, then goes to LEN_L.
  - **LEN_L**: forms `len_tmp = {hi, byte}`. If 1 <= `len_tmp` <= 2**ADDR_WIDTH, commit it to `frame_len_out`; otherwise set `err_out` and leave `frame_len_out` unchanged. Go to IDLE either way.
  - **DATA**: each byte with `wr_ptr < frame_len_out` writes RAM[`wr_ptr`] and increments `wr_ptr`. Bytes at or beyond the length are dropped and the pointer does not wrap. The FSM stays in DATA until `cs_end`.
- `cs_end` forces the FSM to IDLE from any state. If `cs_end` and `spi_rdy_in` occur in the same cycle, the byte is processed first (RAM write, length latch or command) and the next state is still IDLE.
- While in LEN_H or LEN_L, `cs_end` discards the partial length with no commit and no error.
- Show handshake:
  - When `show_pend` is set and `frame_busy_in` is 0, `frame_start_out` pulses for one cycle and `show_pend` clears.
  - While `frame_busy_in` is 1, the request waits.
  - A 0x2C received while a request is already pending is merged: one pulse only.
  - If `frame_len_out` is 0, `show_pend` clears with no pulse.
- `err_out` clears on the next successful length commit.
- RAM writes proceed even when `frame_busy_in` is 1; preventing tearing is the host's responsibility.

## Timing
- Reset values: `ram_wr_en_out` 0, `ram_wr_addr_out` 0, `ram_wr_data_out` 0, `frame_len_out` 0, `frame_start_out` 0, `err_out` 0. FSM resets to IDLE; `show_pend` 0; `wr_ptr` 0.
- All outputs are registered.
- RAM write: `ram_wr_en_out` is high for exactly one cycle, the cycle after `spi_rdy_in`, with address and data valid in that same cycle.
- Length commit: `frame_len_out` updates the cycle after the LEN_L byte's `spi_rdy_in`.
- Show latency, engine idle: `spi_rdy_in` carrying 0x2C in cycle N, `show_pend` set in N+1, `frame_start_out` high in N+2.
- Show latency, engine busy: `frame_start_out` goes high one cycle after the first cycle `frame_busy_in` is sampled 0.
- CS latency: a pin rising edge is seen as `cs_end` 2-3 cycles later. The FSM is in IDLE the cycle after `cs_end`.
- Back-to-back `spi_rdy_in` pulses spaced 2 cycles apart must be sustained without loss.
- Reset mid-frame: everything returns to reset values immediately. A pending show is lost.

## Test plan
- ADDR_WIDTH=9, idle engine. Send 0x2A 0x00 0x06, then 0x2B + 6 bytes 0x10..0x15, then 0x2C. Required: `frame_len_out`=6; writes to addresses 0..5 with data 0x10..0x15; exactly one `frame_start_out` pulse, 2 cycles after the 0x2C pulse.
- Length bounds:
  - Length 0x0201 (513) → `err_out`=1, `frame_len_out` holds its old value.
  - Then length 0x0200 → `frame_len_out`=512, `err_out`=0.
  - Then length 0 → `err_out`=1.
- Overrun: with length 4, send 0x2B + 7 bytes. Required: exactly 4 writes (addresses 0..3), no address wrap; the FSM stays in DATA until CS rises.
- Busy handshake: hold `frame_busy_in`=1 and send 0x2C twice. Required: no pulse while busy; exactly one pulse the cycle after busy drops.
- CS abort:
  - Deassert CS after 0x2A 0x01; a new transaction then sends 0x2B. Required: no length commit and no error; 0x2B is decoded as a command.
  - `cs_end` coincident with the last data byte. Required: that byte is written, then the FSM is in IDLE.
- Assert `rst_n_in` mid-DATA with `show_pend` set. Required: all outputs at reset values asynchronously; no `frame_start_out` after release.
